muldiv_hilo_unit: RTL
=====================

Name: muldiv_hilo_unit

Overview:
- Multi-cycle 32-bit multiply/divide unit that owns the HI and LO registers.
- HI and LO drive the two inputs of the downstream 32-bit 2:1 result mux (sel = mfhi/mflo), which feeds the register-file write-back path.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Supports direct MTHI/MTLO writes.
- Provides Busy/Done for the hazard unit to stall dependent instructions.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  32  multiplicand / dividend (rs)
- B  input  32  multiplier / divisor (rt)
- Hi_Wr  input  1  MTHI: load Wr_Data into HI
- Lo_Wr  input  1  MTLO: load Wr_Data into LO
- Wr_Data  input  32  data for MTHI/MTLO
- Hi  output  32  HI register (to result mux inB)
- Lo  output  32  LO register (to result mux inA)
- Busy  output  1  high while state != IDLE
- Done  output  1  one-cycle pulse when HI/LO take a new result
- Div_By_Zero  output  1  sticky flag; set by DIV/DIVU with B=0, cleared on next accepted Start

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, Div_By_Zero=0, counter=0. Reset mid-operation aborts it; no partial result reaches Hi/Lo.
- States:
  - IDLE: Start=1 at edge k latches Op, |A|, |B| (signed ops take magnitudes) and the result-sign bits, clears Div_By_Zero, zeroes counter -> RUN.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter increments; after the 32nd step (edge k+32) -> FIX.
  - FIX: applies sign correction and writes the 64-bit product {HI,LO}, or quotient into LO and remainder into HI, at edge k+33; Done=1 for the cycle following edge k+33 -> IDLE.
- Latency: Hi/Lo are valid and Done=1 in the cycle after edge k+33. Busy is high from the cycle after edge k through the cycle after edge k+32. Busy is low while Done=1, so a back-to-back Start is accepted in the Done cycle.
- Start while Busy: ignored; no state change.
- Hi_Wr/Lo_Wr:
  - Honoured only in IDLE with Start=0; update takes effect next edge.
  - Both may assert together; both registers load Wr_Data.
  - Ignored while Busy.
  - Start and a write in the same IDLE cycle: Start wins and the write is dropped.
- Signed multiply: 64-bit two's-complement product. Unsigned multiply: 64-bit unsigned product.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): Lo=0x80000000, Hi=0x00000000; not an error.
- Divide by zero (B=0): full latency still applies; Lo=0xFFFFFFFF, Hi=A (raw input); Div_By_Zero=1.
- Multiply by zero needs no special case.
- Hi/Lo change only at reset, in FIX, or on an honoured write; they are stable during RUN.

Test Plan:
- Reset then idle: Hi=0, Lo=0, Busy=0, Done=0. Hi_Wr with Wr_Data=0x12345678 -> Hi=0x12345678 next cycle, Lo unchanged.
- MULT A=7, B=0xFFFFFFFD (-3), Start at edge k -> Busy through edge k+32; Done pulse after edge k+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Immediate second Start in the Done cycle (MULTU 2*3) is accepted -> Hi=0, Lo=6.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x55, B=0 -> Lo=0xFFFFFFFF, Hi=0x55, Div_By_Zero=1. Next Start (DIVU 9/4) clears the flag -> Lo=2, Hi=1.
- Abort and ignore cases:
  - Start while Busy, and Lo_Wr while Busy: both have no effect on the running result.
  - Rst_n low at edge k+10 -> Hi=Lo=0, Busy=0 immediately; no Done pulse follows.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// Issue and result bundle between the decode/hazard logic and the HI/LO multiply/divide unit.
interface muldiv_hilo_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  hi_wr;
   logic                  lo_wr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;

   modport master (
      output start, op, a, b, hi_wr, lo_wr, wr_data,
      input  hi, lo, busy, done, div_by_zero
   );

   modport slave (
      input  start, op, a, b, hi_wr, lo_wr, wr_data,
      output hi, lo, busy, done, div_by_zero
   );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO
// writes and busy/done for the hazard unit.
module muldiv_hilo_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_hilo_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             b_zero;
   logic             done_q;
   logic             dbz_q;
   logic [W-1:0]     hi_q;
   logic [W-1:0]     lo_q;
   logic [W-1:0]     a_raw;
   logic [W-1:0]     mag_b;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_nxt;
   logic [W:0]       mul_sum;
   logic             div_ge;
   logic [W-1:0]     div_sub;

   function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic sgn);
      if (sgn && v[W-1]) return -v;
      else               return v;
   endfunction

   function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*W-1:0] neg_d(input logic [2*W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div
   always_comb begin
      mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : '0);
      div_ge  = acc[2*W-1:W-1] >= {1'b0, mag_b};
      div_sub = acc[2*W-2:W-1] - mag_b;
      acc_nxt = '0;
      if (is_div) begin
         if (div_ge) acc_nxt = {div_sub, acc[W-2:0], 1'b1};
         else        acc_nxt = {acc[2*W-2:0], 1'b0};
      end else begin
         acc_nxt = {mul_sum, acc[W-1:1]};
      end
   end

   // Operand latch and iteration datapath; no reset needed, results only escape via FIX
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.start) begin
         is_div <= bus.op[1];
         a_raw  <= bus.a;
         mag_b  <= magnitude(bus.b, ~bus.op[0]);
         acc    <= {{W{1'b0}}, magnitude(bus.a, ~bus.op[0])};
         neg_q  <= ~bus.op[0] & (bus.a[W-1] ^ bus.b[W-1]);
         neg_r  <= ~bus.op[0] & bus.a[W-1];
         b_zero <= (bus.b == '0);
      end else if (state == RUN) begin
         acc <= acc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dbz_q <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  if (bus.hi_wr) hi_q <= bus.wr_data;
                  if (bus.lo_wr) lo_q <= bus.wr_data;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) state <= FIX;
            end
            FIX: begin
               state  <= IDLE;
               done_q <= 1'b1;
               if (is_div) begin
                  // divide by zero still takes full latency and returns all-ones / raw dividend
                  if (b_zero) begin
                     lo_q  <= '1;
                     hi_q  <= a_raw;
                     dbz_q <= 1'b1;
                  end else begin
                     lo_q <= neg_w(acc[W-1:0], neg_q);
                     hi_q <= neg_w(acc[2*W-1:W], neg_r);
                  end
               end else begin
                  {hi_q, lo_q} <= neg_d(acc, neg_q);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule
